// File: rtl/cluster_address_readout_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_address_readout_pkg
//  Brief    : Shared VPF geometry constants and readout FSM encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package cluster_address_readout_pkg;

    localparam int NUM_VPFS     = 1536;
    localparam int SEG_WIDTH    = 64;
    localparam int MAX_CLUSTERS = 8;
    localparam int ADR_WIDTH    = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cluster_address_readout_lowest_set_bit_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : lowest_set_bit_encoder
//  Brief    : Combinational index of the lowest set bit in a segment.
//  Revision : 1.0 - initial release
// ============================================================================
module lowest_set_bit_encoder #(
    parameter int WIDTH     = 64,
    parameter int IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     bits_i,
    output logic [IDX_WIDTH-1:0] index_o,
    output logic                 found_o
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        index_o = '0;
        found_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bits_i[i]) begin
                index_o = IDX_WIDTH'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cluster_address_readout.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_address_readout
//  Brief    : Streams addresses of set VPF bits, lowest first, capped per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module cluster_address_readout
    import cluster_address_readout_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [NUM_VPFS-1:0]  vpfs_i,
    output logic                 busy_o,
    output logic [ADR_WIDTH-1:0] adr_o,
    output logic                 adr_valid_o,
    input  logic                 adr_ready_i,
    output logic [ADR_WIDTH-1:0] cnt_o,
    output logic                 overflow_o,
    output logic                 done_o
);

    localparam int c_num_segs  = NUM_VPFS / SEG_WIDTH;
    localparam int c_seg_idx_w = $clog2(c_num_segs);
    localparam int c_bit_idx_w = $clog2(SEG_WIDTH);

    state_t                 r_state, w_state_next;
    logic [NUM_VPFS-1:0]    r_work, w_work_cleared;
    logic [c_seg_idx_w-1:0] r_seg;
    logic [ADR_WIDTH-1:0]   r_adr, r_cnt, w_adr_next, w_seg_base;
    logic                   r_adr_valid, r_overflow, r_busy, r_done;
    logic [SEG_WIDTH-1:0]   w_segs [c_num_segs];
    logic [SEG_WIDTH-1:0]   w_seg;
    logic [c_bit_idx_w-1:0] w_bit_idx;
    logic                   w_found, w_slot_free, w_last_load, w_last_seg;
    logic                   w_start, w_load, w_advance, w_finish;

    generate
        for (genvar g = 0; g < c_num_segs; g++) begin : g_seg
            assign w_segs[g] = r_work[g*SEG_WIDTH +: SEG_WIDTH];
        end
    endgenerate

    assign w_seg = w_segs[r_seg];

    lowest_set_bit_encoder #(
        .WIDTH     (SEG_WIDTH),
        .IDX_WIDTH (c_bit_idx_w)
    ) u_lsb_enc (
        .bits_i  (w_seg),
        .index_o (w_bit_idx),
        .found_o (w_found)
    );

    assign w_seg_base  = ADR_WIDTH'(r_seg) * ADR_WIDTH'(SEG_WIDTH);
    assign w_adr_next  = w_seg_base + ADR_WIDTH'(w_bit_idx);
    assign w_slot_free = !r_adr_valid || adr_ready_i;
    assign w_last_load = (r_cnt == ADR_WIDTH'(MAX_CLUSTERS - 1));
    assign w_last_seg  = (r_seg == c_seg_idx_w'(c_num_segs - 1));

    // Work image with the address being emitted removed; also feeds overflow.
    always_comb begin
        w_work_cleared             = r_work;
        w_work_cleared[w_adr_next] = 1'b0;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start      = 1'b1;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_found) begin
                    if (w_slot_free) begin
                        w_load = 1'b1;
                        if (w_last_load) w_state_next = ST_DRAIN;
                    end
                end else begin
                    w_advance = 1'b1;
                    if (w_last_seg) w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_slot_free) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_work      <= '0;
            r_seg       <= '0;
            r_adr       <= '0;
            r_adr_valid <= 1'b0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load)                         r_adr_valid <= 1'b1;
            else if (r_adr_valid && adr_ready_i) r_adr_valid <= 1'b0;
            if (w_start) begin
                r_work     <= vpfs_i;
                r_seg      <= '0;
                r_cnt      <= '0;
                r_overflow <= 1'b0;
                r_busy     <= 1'b1;
            end
            if (w_load) begin
                r_adr  <= w_adr_next;
                r_work <= w_work_cleared;
                r_cnt  <= r_cnt + 1'b1;
                if (w_last_load) r_overflow <= |w_work_cleared;
            end
            // Index parks on the last segment so the mux never leaves range.
            if (w_advance && !w_last_seg) r_seg <= r_seg + 1'b1;
            if (w_finish) r_busy <= 1'b0;
        end
    end

    assign busy_o      = r_busy;
    assign adr_o       = r_adr;
    assign adr_valid_o = r_adr_valid;
    assign cnt_o       = r_cnt;
    assign overflow_o  = r_overflow;
    assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cluster_address_readout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cluster_address_readout
//  Brief    : Directed self-checking bench for cluster_address_readout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_address_readout;
    import cluster_address_readout_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start_i;
    logic [NUM_VPFS-1:0]  vpfs_i;
    logic                 busy_o;
    logic [ADR_WIDTH-1:0] adr_o;
    logic                 adr_valid_o;
    logic                 adr_ready_i;
    logic [ADR_WIDTH-1:0] cnt_o;
    logic                 overflow_o;
    logic                 done_o;

    int checks   = 0;
    int failures = 0;

    int xq[$];
    int cyc           = 0;
    int done_cnt      = 0;
    int done_cyc      = 0;
    int last_xfer_cyc = 0;
    int valid_cnt     = 0;

    always #5 clock = ~clock;

    cluster_address_readout dut (
        .clock       (clock),
        .reset       (reset),
        .start_i     (start_i),
        .vpfs_i      (vpfs_i),
        .busy_o      (busy_o),
        .adr_o       (adr_o),
        .adr_valid_o (adr_valid_o),
        .adr_ready_i (adr_ready_i),
        .cnt_o       (cnt_o),
        .overflow_o  (overflow_o),
        .done_o      (done_o)
    );

    // Observes accepted addresses and done pulses at the active edge.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && adr_valid_o) valid_cnt <= valid_cnt + 1;
        if (!reset && adr_valid_o && adr_ready_i) begin
            xq.push_back(int'(adr_o));
            last_xfer_cyc <= cyc;
        end
        if (!reset && done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [NUM_VPFS-1:0] v);
        @(negedge clock);
        vpfs_i  = v;
        start_i = 1'b1;
        @(negedge clock);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (!done_o && n < limit) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done_timeout"}, 32'(done_o), 32'd1);
    endtask

    initial begin
        logic [NUM_VPFS-1:0] v;
        int base, dbase, vbase, first;

        reset       = 1'b1;
        start_i     = 1'b0;
        vpfs_i      = '0;
        adr_ready_i = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_busy",  32'(busy_o),      32'd0);
        check("rst_valid", 32'(adr_valid_o), 32'd0);
        check("rst_adr",   32'(adr_o),       32'd0);
        check("rst_cnt",   32'(cnt_o),       32'd0);
        check("rst_ovf",   32'(overflow_o),  32'd0);
        check("rst_done",  32'(done_o),      32'd0);
        reset = 1'b0;

        // Empty frame: done lands exactly one cycle after edge T+25.
        vbase = valid_cnt; dbase = done_cnt; first = 0;
        start_frame('0);
        check("empty_busy", 32'(busy_o), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (done_o && first == 0) first = k;
        end
        check("empty_done_k", 32'(first), 32'd25);
        check("empty_valid", 32'(valid_cnt - vbase), 32'd0);
        check("empty_cnt", 32'(cnt_o), 32'd0);
        check("empty_ovf", 32'(overflow_o), 32'd0);
        check("empty_busy_end", 32'(busy_o), 32'd0);
        check("empty_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // Sparse bits across the whole bitmap.
        v = '0; v[5] = 1'b1; v[700] = 1'b1; v[1535] = 1'b1;
        base = xq.size(); dbase = done_cnt;
        start_frame(v);
        wait_done("sparse", 200);
        @(negedge clock);
        check("sparse_done_pulse", 32'(done_o), 32'd0);
        check("sparse_busy", 32'(busy_o), 32'd0);
        check("sparse_n", 32'(xq.size() - base), 32'd3);
        check("sparse_a0", 32'(xq[base]), 32'd5);
        check("sparse_a1", 32'(xq[base+1]), 32'd700);
        check("sparse_a2", 32'(xq[base+2]), 32'd1535);
        check("sparse_cnt", 32'(cnt_o), 32'd3);
        check("sparse_ovf", 32'(overflow_o), 32'd0);
        check("sparse_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // Ten bits set: capped at eight, overflow raised.
        v = '0; v[9:0] = '1;
        base = xq.size(); dbase = done_cnt;
        start_frame(v);
        wait_done("cap", 200);
        @(negedge clock);
        check("cap_n", 32'(xq.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) check("cap_adr", 32'(xq[base+i]), 32'(i));
        check("cap_cnt", 32'(cnt_o), 32'd8);
        check("cap_ovf", 32'(overflow_o), 32'd1);
        check("cap_done_after_xfer", 32'(done_cyc - last_xfer_cyc), 32'd1);
        check("cap_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // Backpressure: address held stable while not ready.
        v = '0; v[5] = 1'b1; v[6] = 1'b1;
        adr_ready_i = 1'b0;
        base = xq.size();
        start_frame(v);
        first = 0;
        while (!adr_valid_o && first < 10) begin
            @(negedge clock);
            first++;
        end
        check("bp_valid", 32'(adr_valid_o), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_hold_adr", 32'(adr_o), 32'd5);
            check("bp_hold_valid", 32'(adr_valid_o), 32'd1);
        end
        adr_ready_i = 1'b1;
        wait_done("bp", 200);
        @(negedge clock);
        check("bp_n", 32'(xq.size() - base), 32'd2);
        check("bp_a0", 32'(xq[base]), 32'd5);
        check("bp_a1", 32'(xq[base+1]), 32'd6);
        check("bp_cnt", 32'(cnt_o), 32'd2);

        // Reset mid-frame after the second transfer.
        v = '0;
        v[3] = 1'b1; v[70] = 1'b1; v[140] = 1'b1; v[200] = 1'b1;
        v[300] = 1'b1; v[400] = 1'b1; v[500] = 1'b1; v[600] = 1'b1;
        base = xq.size(); dbase = done_cnt;
        start_frame(v);
        first = 0;
        while (xq.size() - base < 2 && first < 100) begin
            @(negedge clock);
            first++;
        end
        check("mrst_two_xfers", 32'(xq.size() - base), 32'd2);
        reset = 1'b1;
        @(negedge clock);
        check("mrst_valid", 32'(adr_valid_o), 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_cnt", 32'(cnt_o), 32'd0);
        check("mrst_ovf", 32'(overflow_o), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("mrst_no_done", 32'(done_cnt - dbase), 32'd0);
        check("mrst_no_extra", 32'(xq.size() - base), 32'd2);
        check("mrst_idle", 32'(busy_o), 32'd0);
        v = '0; v[9] = 1'b1; v[1000] = 1'b1;
        base = xq.size(); dbase = done_cnt;
        start_frame(v);
        wait_done("post", 200);
        @(negedge clock);
        check("post_n", 32'(xq.size() - base), 32'd2);
        check("post_a0", 32'(xq[base]), 32'd9);
        check("post_a1", 32'(xq[base+1]), 32'd1000);
        check("post_cnt", 32'(cnt_o), 32'd2);
        check("post_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // start_i and a new bitmap mid-frame must be ignored.
        v = '0; v[20] = 1'b1; v[30] = 1'b1;
        base = xq.size(); dbase = done_cnt;
        start_frame(v);
        repeat (2) @(negedge clock);
        v = '0; v[40] = 1'b1; v[1100] = 1'b1;
        vpfs_i  = v;
        start_i = 1'b1;
        @(negedge clock);
        start_i = 1'b0;
        wait_done("ign", 200);
        repeat (5) @(negedge clock);
        check("ign_n", 32'(xq.size() - base), 32'd2);
        check("ign_a0", 32'(xq[base]), 32'd20);
        check("ign_a1", 32'(xq[base+1]), 32'd30);
        check("ign_cnt", 32'(cnt_o), 32'd2);
        check("ign_busy", 32'(busy_o), 32'd0);
        check("ign_done_cnt", 32'(done_cnt - dbase), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
